// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: multi-cycle ops hold busy for a fixed latency, then commit.
// Define MDU_MADD_EN to enable the MADD/MADDU multiply-accumulate ops (110/111).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;

  logic             isMul, isDiv, isMadd;
  logic             acceptMulti, acceptMove, lastCycle;
  logic [CNT_W-1:0] latency;

  logic             opSigned;
  logic [63:0]      aExt, bExt, product;
  logic             aNeg, bNeg, divByZero;
  logic [31:0]      aMag, bMag, qMag, rMag, quot, rem;
  logic [31:0]      resHi, resLo;
  logic             commitEn;

  always_comb begin : decode
    isMul = (op == OP_MULT) || (op == OP_MULTU);
    isDiv = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
    isMadd = (op == OP_MADD) || (op == OP_MADDU);
`else
    isMadd = 1'b0;
`endif
    acceptMulti = (state_q == IDLE) && start && (isMul || isDiv || isMadd);
    acceptMove  = (state_q == IDLE) && start && ((op == OP_MTHI) || (op == OP_MTLO));
    latency     = isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    lastCycle   = (state_q == RUN) && (cnt_q <= CNT_W'(1));
  end

  // Results come only from the latched operands; bit 0 of the op selects unsigned.
  always_comb begin : datapath
    opSigned = ~op_q[0];
    aExt     = {{32{opSigned & a_q[31]}}, a_q};
    bExt     = {{32{opSigned & b_q[31]}}, b_q};
    product  = aExt * bExt;

    aNeg      = opSigned & a_q[31];
    bNeg      = opSigned & b_q[31];
    aMag      = aNeg ? (~a_q + 32'd1) : a_q;
    bMag      = bNeg ? (~b_q + 32'd1) : b_q;
    divByZero = (b_q == 32'd0);
    qMag      = divByZero ? 32'd0 : (aMag / bMag);
    rMag      = divByZero ? 32'd0 : (aMag % bMag);
    quot      = (aNeg ^ bNeg) ? (~qMag + 32'd1) : qMag;
    rem       = aNeg ? (~rMag + 32'd1) : rMag;

    resHi    = product[63:32];
    resLo    = product[31:0];
    commitEn = 1'b1;
    case (op_q)
      OP_DIV, OP_DIVU: begin
        resHi    = rem;
        resLo    = quot;
        commitEn = ~divByZero;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        {resHi, resLo} = {hi_q, lo_q} + product;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin : stateReg
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 3'b000;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin : nextState
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (acceptMulti) begin
          state_d = RUN;
          cnt_d   = latency;
        end
      end
      RUN: begin
        if (lastCycle) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Start requests while RUN are dropped: acceptMulti/acceptMove only fire in IDLE.
  always_comb begin : outputLogic
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    if (acceptMulti) begin
      op_d = op;
      a_d  = srcA;
      b_d  = srcB;
    end
    if (acceptMove) begin
      if (op == OP_MTLO) lo_d = srcA;
      else               hi_d = srcA;
    end
    if (lastCycle) begin
      done_d = 1'b1;
      if (commitEn) begin
        hi_d = resHi;
        lo_d = resLo;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
